// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode map, FSM states, select encodings
// and the control word that the decoder hands to the top level.
package cpu_ctrl_pkg;

   localparam logic [4:0] OpAlu    = 5'b00000;
   localparam logic [4:0] OpLhi    = 5'b00001;
   localparam logic [4:0] OpLli    = 5'b00010;
   localparam logic [4:0] OpLdrImm = 5'b00011;
   localparam logic [4:0] OpLdrReg = 5'b00100;
   localparam logic [4:0] OpStrImm = 5'b00101;
   localparam logic [4:0] OpStrReg = 5'b00110;  // shared with CMP, split by ALU_Op
   localparam logic [4:0] OpAddi   = 5'b00111;
   localparam logic [4:0] OpSubi   = 5'b01000;
   localparam logic [4:0] OpMov    = 5'b01011;
   localparam logic [4:0] OpJmp    = 5'b10000;
   localparam logic [4:0] OpJalL   = 5'b10001;
   localparam logic [4:0] OpJalR   = 5'b10010;
   localparam logic [4:0] OpJr     = 5'b10011;
   localparam logic [4:0] OpBranch = 5'b11000;
   localparam logic [4:0] OpSys    = 5'b11100;

   localparam logic [1:0] AluOpMem  = 2'b00;
   localparam logic [1:0] AluOpCmp  = 2'b01;
   localparam logic [1:0] AluOpOutr = 2'b00;
   localparam logic [1:0] AluOpHlt  = 2'b01;

   localparam logic [2:0] CondZ  = 3'b000;
   localparam logic [2:0] CondNz = 3'b001;
   localparam logic [2:0] CondC  = 3'b010;
   localparam logic [2:0] CondNc = 3'b011;
   localparam logic [2:0] CondAl = 3'b110;

   localparam logic [1:0] AluBRn     = 2'b00;
   localparam logic [1:0] AluBImm    = 2'b01;
   localparam logic [1:0] AluBNegImm = 2'b10;
   localparam logic [1:0] AluBZero   = 2'b11;

   localparam logic [1:0] ImmS5  = 2'b00;
   localparam logic [1:0] ImmBr  = 2'b01;
   localparam logic [1:0] ImmLli = 2'b10;
   localparam logic [1:0] ImmLhi = 2'b11;

   localparam logic [1:0] PcInc = 2'b00;
   localparam logic [1:0] PcJmp = 2'b01;
   localparam logic [1:0] PcReg = 2'b10;

   localparam logic [1:0] RfWdMem = 2'b00;
   localparam logic [1:0] RfWdImm = 2'b01;
   localparam logic [1:0] RfWdAlu = 2'b10;
   localparam logic [1:0] RfWdPc  = 2'b11;

   typedef enum logic [3:0] {
      StIdle, StFetch, StDecode, StExecAlu, StWbAlu, StWbImm, StMemAddr,
      StMemRd, StLdWb, StMemWr, StBranch, StJump, StOutr, StHalt
   } state_e;

   typedef struct packed {
      logic       ir_ce;
      logic       pc_ce;
      logic       pc_add_src;
      logic       pc_alu_sel;
      logic       mem_addr_sel;
      logic       memw_data_sel;
      logic       memw_en;
      logic [1:0] pc_sel;
      logic [1:0] imm_sel;
      logic [1:0] alu_b_sel;
      logic [1:0] rf_wd_sel;
      logic       alu_control;
      logic       z_ce;
      logic       c_ce;
      logic       rd_reg_ce;
      logic       aluout_reg_ce;
      logic       rf_write_en;
      logic       out_r_ce;
      logic       rd_rm_sel;
   } ctrl_t;

   function automatic logic branch_taken(input logic [2:0] cond, input logic z, input logic c);
      case (cond)
         CondZ:   return z;
         CondNz:  return ~z;
         CondC:   return c;
         CondNc:  return ~c;
         CondAl:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_cmp(input logic [4:0] opcode, input logic [1:0] alu_op);
      return (opcode == OpStrReg) && (alu_op == AluOpCmp);
   endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Bundle between the controller and the datapath: IR fields and flags in, control word out.
interface multi_cycle_control_unit_if;
   logic       start;
   logic       ext_we;
   logic [4:0] Opcode;
   logic [1:0] ALU_Op;
   logic [2:0] Rd_Addr;
   logic       Z_Reg;
   logic       C_Reg;
   logic       IR_CE;
   logic       PC_CE;
   logic       PC_Add_Src;
   logic       PC_ALU_Sel;
   logic       Mem_Addr_Sel;
   logic       MemW_Data_Sel;
   logic       MemW_en;
   logic [1:0] PC_Sel;
   logic [1:0] Imm_Sel;
   logic [1:0] ALU_B_Sel;
   logic [1:0] RF_Write_Data_Sel;
   logic       ALU_Control;
   logic       Z_CE;
   logic       C_CE;
   logic       Rd_Reg_CE;
   logic       ALUOut_Reg_CE;
   logic       RF_Write_en;
   logic       Out_R_CE;
   logic       Rd_Rm_Sel;
   logic       halted;

   modport master (
      input  start, ext_we, Opcode, ALU_Op, Rd_Addr, Z_Reg, C_Reg,
      output IR_CE, PC_CE, PC_Add_Src, PC_ALU_Sel, Mem_Addr_Sel, MemW_Data_Sel, MemW_en,
             PC_Sel, Imm_Sel, ALU_B_Sel, RF_Write_Data_Sel, ALU_Control, Z_CE, C_CE,
             Rd_Reg_CE, ALUOut_Reg_CE, RF_Write_en, Out_R_CE, Rd_Rm_Sel, halted
   );

   modport slave (
      output start, ext_we, Opcode, ALU_Op, Rd_Addr, Z_Reg, C_Reg,
      input  IR_CE, PC_CE, PC_Add_Src, PC_ALU_Sel, Mem_Addr_Sel, MemW_Data_Sel, MemW_en,
             PC_Sel, Imm_Sel, ALU_B_Sel, RF_Write_Data_Sel, ALU_Control, Z_CE, C_CE,
             Rd_Reg_CE, ALUOut_Reg_CE, RF_Write_en, Out_R_CE, Rd_Rm_Sel, halted
   );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decoder: maps the current state and IR fields to datapath controls.
module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic [4:0] opcode_i,
   input  logic [2:0] rd_addr_i,
   input  logic       z_i,
   input  logic       c_i,
   input  logic       ext_we_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         StIdle: begin
            ctrl_o.mem_addr_sel  = 1'b1;
            ctrl_o.memw_data_sel = 1'b1;
            ctrl_o.memw_en       = ext_we_i;
         end
         StFetch: begin
            ctrl_o.ir_ce = 1'b1;
            ctrl_o.pc_ce = 1'b1;
         end
         StDecode: ctrl_o.rd_reg_ce = 1'b1;
         StExecAlu: begin
            ctrl_o.aluout_reg_ce = 1'b1;
            ctrl_o.z_ce          = 1'b1;
            ctrl_o.c_ce          = 1'b1;
            case (opcode_i)
               OpAddi: ctrl_o.alu_b_sel = AluBImm;
               OpSubi: ctrl_o.alu_b_sel = AluBNegImm;
               OpMov: begin
                  ctrl_o.alu_b_sel = AluBZero;
                  ctrl_o.z_ce      = 1'b0;
                  ctrl_o.c_ce      = 1'b0;
               end
               // reg-reg ops and CMP: ALU_Op picks the function (CMP carries SUB)
               default: begin
                  ctrl_o.alu_b_sel   = AluBRn;
                  ctrl_o.alu_control = 1'b1;
               end
            endcase
         end
         StWbAlu: begin
            ctrl_o.rf_write_en = 1'b1;
            ctrl_o.rf_wd_sel   = RfWdAlu;
         end
         StWbImm: begin
            ctrl_o.rf_write_en = 1'b1;
            ctrl_o.rf_wd_sel   = RfWdImm;
            ctrl_o.imm_sel     = (opcode_i == OpLhi) ? ImmLhi : ImmLli;
         end
         StMemAddr: begin
            ctrl_o.aluout_reg_ce = 1'b1;
            ctrl_o.alu_b_sel = (opcode_i == OpLdrImm || opcode_i == OpStrImm) ? AluBImm : AluBRn;
         end
         StMemRd: ctrl_o.pc_alu_sel = 1'b1;
         StLdWb: begin
            ctrl_o.rf_write_en = 1'b1;
            ctrl_o.rf_wd_sel   = RfWdMem;
         end
         StMemWr: begin
            ctrl_o.pc_alu_sel = 1'b1;
            ctrl_o.memw_en    = 1'b1;
         end
         StBranch: begin
            ctrl_o.imm_sel    = ImmBr;
            ctrl_o.pc_add_src = 1'b1;
            ctrl_o.pc_sel     = PcInc;
            ctrl_o.pc_ce      = branch_taken(rd_addr_i, z_i, c_i);
         end
         StJump: begin
            ctrl_o.pc_ce = 1'b1;
            case (opcode_i)
               OpJmp: ctrl_o.pc_sel = PcJmp;
               OpJalL: begin
                  ctrl_o.rf_wd_sel   = RfWdPc;
                  ctrl_o.rf_write_en = 1'b1;
                  ctrl_o.pc_add_src  = 1'b1;
                  ctrl_o.imm_sel     = ImmBr;
               end
               OpJalR: begin
                  ctrl_o.rf_wd_sel   = RfWdPc;
                  ctrl_o.rf_write_en = 1'b1;
                  ctrl_o.pc_sel      = PcReg;
                  ctrl_o.rd_rm_sel   = 1'b1;
               end
               default: ctrl_o.pc_sel = PcReg;
            endcase
         end
         StOutr: ctrl_o.out_r_ce = 1'b1;
         StHalt: ;
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle controller top: state register, next-state sequencing and the registered halt flag.
module multi_cycle_control_unit
   import cpu_ctrl_pkg::*;
(
   input logic                          clk,
   input logic                          rst,
   multi_cycle_control_unit_if.master   bus
);

   state_e state_q, state_d;
   logic   halted_q, halted_d;
   ctrl_t  ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StFetch;
         StFetch: state_d = StDecode;
         StDecode: begin
            case (bus.Opcode)
               OpAlu, OpAddi, OpSubi, OpMov:  state_d = StExecAlu;
               OpLhi, OpLli:                  state_d = StWbImm;
               OpLdrImm, OpLdrReg, OpStrImm:  state_d = StMemAddr;
               OpStrReg: begin
                  if (bus.ALU_Op == AluOpMem)      state_d = StMemAddr;
                  else if (bus.ALU_Op == AluOpCmp) state_d = StExecAlu;
                  else                             state_d = StFetch;
               end
               OpBranch:                      state_d = StBranch;
               OpJmp, OpJalL, OpJalR, OpJr:   state_d = StJump;
               OpSys: begin
                  if (bus.ALU_Op == AluOpOutr)     state_d = StOutr;
                  else if (bus.ALU_Op == AluOpHlt) state_d = StHalt;
                  else                             state_d = StFetch;
               end
               default:                       state_d = StFetch;
            endcase
         end
         StExecAlu: state_d = is_cmp(bus.Opcode, bus.ALU_Op) ? StFetch : StWbAlu;
         StMemAddr: begin
            state_d = (bus.Opcode == OpLdrImm || bus.Opcode == OpLdrReg) ? StMemRd : StMemWr;
         end
         StMemRd: state_d = StLdWb;
         StHalt:  state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // halted tracks the state register, so it is high exactly while sitting in HALT
   assign halted_d = (state_d == StHalt);

   cpu_ctrl_decode u_decode (
      .state_i   (state_q),
      .opcode_i  (bus.Opcode),
      .rd_addr_i (bus.Rd_Addr),
      .z_i       (bus.Z_Reg),
      .c_i       (bus.C_Reg),
      .ext_we_i  (bus.ext_we),
      .ctrl_o    (ctrl)
   );

   assign bus.IR_CE             = ctrl.ir_ce;
   assign bus.PC_CE             = ctrl.pc_ce;
   assign bus.PC_Add_Src        = ctrl.pc_add_src;
   assign bus.PC_ALU_Sel        = ctrl.pc_alu_sel;
   assign bus.Mem_Addr_Sel      = ctrl.mem_addr_sel;
   assign bus.MemW_Data_Sel     = ctrl.memw_data_sel;
   assign bus.MemW_en           = ctrl.memw_en;
   assign bus.PC_Sel            = ctrl.pc_sel;
   assign bus.Imm_Sel           = ctrl.imm_sel;
   assign bus.ALU_B_Sel         = ctrl.alu_b_sel;
   assign bus.RF_Write_Data_Sel = ctrl.rf_wd_sel;
   assign bus.ALU_Control       = ctrl.alu_control;
   assign bus.Z_CE              = ctrl.z_ce;
   assign bus.C_CE              = ctrl.c_ce;
   assign bus.Rd_Reg_CE         = ctrl.rd_reg_ce;
   assign bus.ALUOut_Reg_CE     = ctrl.aluout_reg_ce;
   assign bus.RF_Write_en       = ctrl.rf_write_en;
   assign bus.Out_R_CE          = ctrl.out_r_ce;
   assign bus.Rd_Rm_Sel         = ctrl.rd_rm_sel;
   assign bus.halted            = halted_q;

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
Multi-cycle controller for the 16-bit RISC datapath. It takes the decoded instruction fields and flags from Complete_Datapath and drives every datapath control input. It sequences fetch, decode, execute, memory and write-back cycles per instruction. It also gives an external loader access to memory while idle, and stops on HLT.

Parameters:
None. The opcode map and the state encoding are fixed in the shared package.

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching at the current PC
ext_we  in  1  loader write strobe; used only in IDLE
Opcode  in  5  IR[15:11]
ALU_Op  in  2  IR[1:0]
Rd_Addr  in  3  IR[10:8]; holds the branch condition for opcode 11000
Z_Reg, C_Reg  in  1 each  datapath flags
IR_CE  out  1  instruction register load
PC_CE, PC_Add_Src, PC_ALU_Sel, Mem_Addr_Sel, MemW_Data_Sel, MemW_en  out  1 each  datapath controls
PC_Sel, Imm_Sel, ALU_B_Sel, RF_Write_Data_Sel  out  2 each  datapath selects
ALU_Control, Z_CE, C_CE, Rd_Reg_CE, ALUOut_Reg_CE, RF_Write_en, Out_R_CE, Rd_Rm_Sel  out  1 each
halted  out  1  high in HALT

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE; halted=0; every output is 0 apart from the IDLE loader defaults below. Reset in any state, including mid-instruction or HALT, returns to IDLE on the next posedge.
- Outputs are combinational from the state and the IR fields. halted is registered.
- Select encodings:
  - ALU_B_Sel: 00=Rn, 01=Imm_Out, 10=negated Imm_Out, 11=constant 0.
  - ALU_Control: 0=ADD, 1=operation given by ALU_Op.
  - Rd_Rm_Sel: 0=Rd, 1=Rm as the PC source.
- IDLE: Mem_Addr_Sel=1, MemW_Data_Sel=1, MemW_en=ext_we. start=1 moves to FETCH; start is ignored outside IDLE.
- FETCH: Mem_Addr_Sel=0, PC_ALU_Sel=0, IR_CE=1, PC_CE=1, PC_Sel=00, PC_Add_Src=0 (PC<-PC+1). Next state DECODE.
- DECODE: Rd_Reg_CE=1, then dispatch on Opcode:
  - 00000 or 00110 with ALU_Op=01 (CMP) -> EXEC_ALU.
  - 00111, 01000, 01011 -> EXEC_ALU.
  - 00001, 00010 -> WB_IMM.
  - 00011, 00100, 00101, 00110 with ALU_Op=00 -> MEM_ADDR.
  - 11000 -> BRANCH.
  - 10000, 10001, 10010, 10011 -> JUMP.
  - 11100 with ALU_Op=00 -> OUTR; 11100 with ALU_Op=01 -> HALT.
  - Any other code -> FETCH (NOP).
- EXEC_ALU: ALUOut_Reg_CE=1.
  - Reg-reg ops: ALU_B_Sel=00, ALU_Control=1.
  - ADDI: ALU_B_Sel=01, Imm_Sel=00, ALU_Control=0.
  - SUBI: ALU_B_Sel=10, Imm_Sel=00, ALU_Control=0.
  - MOV: ALU_B_Sel=11, ALU_Control=0.
  - Z_CE=C_CE=1 for every op except MOV. CMP uses ALU_Control=1 with the SUB function forced.
  - CMP goes to FETCH; all others go to WB_ALU.
- WB_ALU: RF_Write_en=1, RF_Write_Data_Sel=10. Next state FETCH.
- WB_IMM: RF_Write_en=1, RF_Write_Data_Sel=01, Imm_Sel=11 for LHI, 10 for LLI. Next state FETCH.
- MEM_ADDR: ALU adds Rm plus Imm5 (imm forms, ALU_B_Sel=01) or Rn (reg forms, ALU_B_Sel=00); ALUOut_Reg_CE=1. Loads go to MEM_RD, stores to MEM_WR.
- MEM_RD: PC_ALU_Sel=1, Mem_Addr_Sel=0. Next state LD_WB.
- LD_WB: RF_Write_en=1, RF_Write_Data_Sel=00. Next state FETCH.
- MEM_WR: PC_ALU_Sel=1, MemW_en=1, MemW_Data_Sel=0. Next state FETCH.
- BRANCH: Imm_Sel=01, PC_Add_Src=1, PC_Sel=00. PC_CE=1 only if the condition is taken; then FETCH.
  - Conditions: 000 Z, 001 ~Z, 010 C, 011 ~C, 110 always.
  - Codes 100, 101, 111 are never taken.
  - Offset is applied to the already-incremented PC.
- JUMP (single cycle, then FETCH):
  - JMP: PC_Sel=01.
  - JAL label: RF_Write_Data_Sel=11, RF_Write_en=1, PC_Sel=00, PC_Add_Src=1, Imm_Sel=01.
  - JAL Rd,Rm: RF write of PC, PC_Sel=10, Rd_Rm_Sel=1.
  - JR: PC_Sel=10, Rd_Rm_Sel=0.
  - PC_CE=1 in all four cases. The RF receives the incremented PC value from before the jump.
- OUTR: Out_R_CE=1. Next state FETCH.
- HALT: all enables 0, halted=1. Stays in HALT until rst.
- Cycle counts:
  - ALU op: 4.
  - CMP, LHI/LLI, branch, jump, OUTR: 3.
  - LDR: 5.
  - STR: 4.
- No two enables of the same register are ever asserted in the same state.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - the state enum (IDLE, FETCH, DECODE, EXEC_ALU, WB_ALU, WB_IMM, MEM_ADDR, MEM_RD, LD_WB, MEM_WR, BRANCH, JUMP, OUTR, HALT);
  - the branch condition codes;
  - the select encodings.
- Sub-module cpu_ctrl_decode: combinational mapping of (state, Opcode, ALU_Op, Rd_Addr, Z_Reg, C_Reg) to the control word. The top level holds only the state register and the next-state logic.

Test Plan:
- rst=1, then ext_we pulses in IDLE -> MemW_en follows ext_we, Mem_Addr_Sel=1, halted=0, state IDLE.
- start with Opcode=00000, ALU_Op=00 -> FETCH, DECODE, EXEC_ALU (ALUOut_Reg_CE=1, Z_CE=1), WB_ALU (RF_Write_en=1, RF_Write_Data_Sel=10), back to FETCH after 4 cycles.
- Opcode=00011 (LDR imm) -> MEM_ADDR (ALU_B_Sel=01), MEM_RD (PC_ALU_Sel=1), LD_WB (RF_Write_Data_Sel=00); 5 cycles in total.
- Opcode=11000 with Rd_Addr=011: C_Reg=0 -> PC_CE=1, PC_Add_Src=1 in BRANCH; C_Reg=1 -> PC_CE=0. Rd_Addr=110 is always taken.
- Opcode=10001 -> in JUMP, RF_Write_Data_Sel=11, RF_Write_en=1, PC_CE=1, PC_Add_Src=1 all in the same cycle.
- Opcode=11100, ALU_Op=01 -> HALT with halted=1 and held for 50 cycles; rst pulse -> IDLE and halted=0 the next cycle. rst asserted during MEM_RD -> IDLE.
